// File: rtl/atari_input_pkg.sv
// Shared types and constants for the scripted Atari input player.
package atari_input_pkg;

    localparam int BTN_W = 7;
    localparam int SW_W  = 4;

    localparam int BTN_RESET  = 0;
    localparam int BTN_FIRE   = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 4;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } player_state_e;

endpackage

// File: rtl/atari_script_mem.sv
// Script storage: register file with one synchronous write port and an asynchronous read port.
module atari_script_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 27
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; entries past the fill count are never read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/atari_input_player.sv
// Replays a recorded script of button/switch states, one entry per run of video frames.
module atari_input_player
    import atari_input_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 16
) (
    input  logic                            clk_pixel,
    input  logic                            reset,
    input  logic                            vsync,
    input  logic [BTN_W-1:0]                btn_live,
    input  logic [SW_W-1:0]                 sw_live,
    input  logic                            prog_valid,
    output logic                            prog_ready,
    input  logic [SW_W+BTN_W+FRAME_W-1:0]   prog_data,
    input  logic                            start,
    input  logic                            clear,
    input  logic                            abort,
    output logic [BTN_W-1:0]                btn_out,
    output logic [SW_W-1:0]                 sw_out,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(DEPTH)-1:0]        entry_idx,
    output logic [FRAME_W-1:0]              frame_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = SW_W + BTN_W + FRAME_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    player_state_e       state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FRAME_W-1:0]  remaining_q, remaining_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [BTN_W-1:0]    btn_q, btn_d;
    logic [SW_W-1:0]     sw_q, sw_d;
    logic                vsync_q;

    logic                tick;
    logic                clr_req;
    logic                wr_en;
    logic                last_entry;
    logic [AW-1:0]       rd_addr;
    logic [ENTRY_W-1:0]  rd_data;
    logic [BTN_W-1:0]    ent_btn;
    logic [SW_W-1:0]     ent_sw;
    logic [FRAME_W-1:0]  ent_dur;

    assign tick       = vsync & ~vsync_q;
    assign prog_ready = (state_q == IDLE) && (count_q < DEPTH_C);
    assign clr_req    = (state_q == IDLE) && clear && (count_q != '0);
    assign wr_en      = prog_valid && prog_ready && !clr_req;
    assign last_entry = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

    // ARMED fetches entry 0; PLAY pre-fetches the entry that follows the current one.
    assign rd_addr = (state_q == ARMED) ? '0 : rd_ptr_q + 1'b1;

    atari_script_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .clk_i   (clk_pixel),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (prog_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign ent_sw  = rd_data[ENTRY_W-1 -: SW_W];
    assign ent_btn = rd_data[FRAME_W +: BTN_W];
    assign ent_dur = (rd_data[FRAME_W-1:0] == '0) ? FRAME_W'(1) : rd_data[FRAME_W-1:0];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        frame_cnt_d = frame_cnt_q;
        btn_d       = btn_q;
        sw_d        = sw_q;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            btn_d   = btn_live;
            sw_d    = sw_live;
        end else begin
            case (state_q)
                IDLE: begin
                    btn_d = btn_live;
                    sw_d  = sw_live;
                    if (clr_req) begin
                        count_d  = '0;
                        wr_ptr_d = '0;
                    end else if (wr_en) begin
                        count_d  = count_q + 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    // Starting alongside a clear would arm an empty script, so clear wins.
                    if (start && !abort && !clr_req && count_q != '0) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    btn_d = btn_live;
                    sw_d  = sw_live;
                    if (tick) begin
                        state_d     = PLAY;
                        rd_ptr_d    = '0;
                        remaining_d = ent_dur;
                        frame_cnt_d = '0;
                        btn_d       = ent_btn;
                        sw_d        = ent_sw;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        frame_cnt_d = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 1'b1;
                        if (remaining_q > FRAME_W'(1)) begin
                            remaining_d = remaining_q - 1'b1;
                        end else if (!last_entry) begin
                            rd_ptr_d    = rd_ptr_q + 1'b1;
                            remaining_d = ent_dur;
                            btn_d       = ent_btn;
                            sw_d        = ent_sw;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    btn_d   = btn_live;
                    sw_d    = sw_live;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            frame_cnt_q <= '0;
            btn_q       <= '0;
            sw_q        <= '0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            frame_cnt_q <= frame_cnt_d;
            btn_q       <= btn_d;
            sw_q        <= sw_d;
            vsync_q     <= vsync;
        end
    end

    assign btn_out   = btn_q;
    assign sw_out    = sw_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign entry_idx = rd_ptr_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_atari_input_player.sv
// Scoreboard bench for atari_input_player: stimulus queues timed expectations, a monitor checks them.
module tb_atari_input_player;

    localparam int DEPTH   = 16;
    localparam int FRAME_W = 16;

    localparam int SEL_BTN   = 0;
    localparam int SEL_SW    = 1;
    localparam int SEL_BUSY  = 2;
    localparam int SEL_READY = 3;
    localparam int SEL_FCNT  = 4;
    localparam int SEL_IDX   = 5;

    logic               clk_pixel = 1'b0;
    logic               reset = 1'b1;
    logic               vsync = 1'b0;
    logic [6:0]         btn_live = '0;
    logic [3:0]         sw_live = '0;
    logic               prog_valid = 1'b0;
    logic               prog_ready;
    logic [26:0]        prog_data = '0;
    logic               start = 1'b0;
    logic               clear = 1'b0;
    logic               abort = 1'b0;
    logic [6:0]         btn_out;
    logic [3:0]         sw_out;
    logic               busy;
    logic               done;
    logic [3:0]         entry_idx;
    logic [15:0]        frame_cnt;

    atari_input_player #(
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .vsync      (vsync),
        .btn_live   (btn_live),
        .sw_live    (sw_live),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .start      (start),
        .clear      (clear),
        .abort      (abort),
        .btn_out    (btn_out),
        .sw_out     (sw_out),
        .busy       (busy),
        .done       (done),
        .entry_idx  (entry_idx),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_pixel = ~clk_pixel;

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t expQ[$];
    int   doneQ[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] pick(int sel);
        case (sel)
            SEL_BTN:   return 32'(btn_out);
            SEL_SW:    return 32'(sw_out);
            SEL_BUSY:  return 32'(busy);
            SEL_READY: return 32'(prog_ready);
            SEL_FCNT:  return 32'(frame_cnt);
            SEL_IDX:   return 32'(entry_idx);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: samples mid-cycle, retires expectations due this cycle and audits every done pulse.
    always @(posedge clk_pixel) begin
        #4;
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].cyc == cyc) begin
                checks++;
                if (pick(expQ[i].sel) !== expQ[i].val) begin
                    errors++;
                    $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h",
                             expQ[i].name, cyc, pick(expQ[i].sel), expQ[i].val);
                end
                expQ.delete(i);
            end
        end
        if (done !== 1'b0) begin
            int hit;
            hit = -1;
            foreach (doneQ[k]) if (doneQ[k] == cyc) hit = k;
            checks++;
            if (hit < 0) begin
                errors++;
                $display("[TB] FAIL done_pulse cyc=%0d got=%b expected=0", cyc, done);
            end else begin
                doneQ.delete(hit);
            end
        end
    end

    task automatic expectAt(int c, string nm, int sel, logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.sel  = sel;
        e.val  = v;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic frameTick();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
    endtask

    task automatic progWrite(logic [3:0] s, logic [6:0] b, logic [15:0] d);
        prog_valid = 1'b1;
        prog_data  = {s, b, d};
        step();
        prog_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [6:0] expBtn [1:5];
        expBtn[1] = 7'h02; expBtn[2] = 7'h02; expBtn[3] = 7'h08;
        expBtn[4] = 7'h08; expBtn[5] = 7'h08;

        // Reset state
        step(); step();
        expectAt(cyc, "rst_btn",   SEL_BTN,   32'h0);
        expectAt(cyc, "rst_sw",    SEL_SW,    32'h0);
        expectAt(cyc, "rst_busy",  SEL_BUSY,  32'h0);
        expectAt(cyc, "rst_fcnt",  SEL_FCNT,  32'h0);
        expectAt(cyc, "rst_idx",   SEL_IDX,   32'h0);
        reset = 1'b0;
        step();
        expectAt(cyc, "rst_ready", SEL_READY, 32'h1);

        // Two-entry script playback
        progWrite(4'h3, 7'h02, 16'd3);
        progWrite(4'h5, 7'h08, 16'd2);
        btn_live = 7'h7F;
        pulseStart();
        expectAt(cyc, "armed_busy",  SEL_BUSY,  32'h1);
        expectAt(cyc, "armed_live",  SEL_BTN,   32'h7F);
        expectAt(cyc, "armed_ready", SEL_READY, 32'h0);
        frameTick();
        expectAt(cyc, "play0_btn",  SEL_BTN,  32'h02);
        expectAt(cyc, "play0_sw",   SEL_SW,   32'h3);
        expectAt(cyc, "play0_fcnt", SEL_FCNT, 32'h0);
        expectAt(cyc, "play0_idx",  SEL_IDX,  32'h0);
        step();
        for (int i = 1; i <= 5; i++) begin
            frameTick();
            expectAt(cyc, "play_btn",  SEL_BTN,  32'(expBtn[i]));
            expectAt(cyc, "play_fcnt", SEL_FCNT, 32'(i));
            if (i == 3) begin
                expectAt(cyc, "play1_sw",  SEL_SW,  32'h5);
                expectAt(cyc, "play1_idx", SEL_IDX, 32'h1);
            end
            if (i == 5) doneQ.push_back(cyc);
            step();
        end
        expectAt(cyc, "after_done_busy", SEL_BUSY, 32'h0);
        expectAt(cyc, "after_done_btn",  SEL_BTN,  32'h7F);
        expectAt(cyc, "after_done_fcnt", SEL_FCNT, 32'd5);

        // start with abort in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        expectAt(cyc, "start_abort_busy", SEL_BUSY, 32'h0);
        step();
        expectAt(cyc, "start_abort_busy2", SEL_BUSY, 32'h0);

        // Replay, then abort coinciding with a frame tick
        pulseStart();
        frameTick();
        expectAt(cyc, "replay_btn", SEL_BTN,  32'h02);
        expectAt(cyc, "replay_idx", SEL_IDX,  32'h0);
        step();
        btn_live = 7'h40;
        abort = 1'b1;
        vsync = 1'b1;
        step();
        abort = 1'b0;
        vsync = 1'b0;
        expectAt(cyc, "abort_busy", SEL_BUSY, 32'h0);
        expectAt(cyc, "abort_fcnt", SEL_FCNT, 32'h0);
        step();
        expectAt(cyc, "abort_live_btn", SEL_BTN,   32'h40);
        expectAt(cyc, "abort_ready",    SEL_READY, 32'h1);

        // Clear wins over a coincident write; empty script ignores start
        clear = 1'b1;
        prog_valid = 1'b1;
        prog_data = {4'h0, 7'h55, 16'd1};
        step();
        clear = 1'b0;
        prog_valid = 1'b0;
        pulseStart();
        expectAt(cyc, "empty_start_busy", SEL_BUSY, 32'h0);

        // Fill past capacity with prog_valid held high
        prog_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            prog_data = {4'(i), 7'(i + 1), 16'd0};
            if (i == DEPTH) prog_data = {4'hF, 7'h70, 16'd0};
            step();
            expectAt(cyc, "fill_ready", SEL_READY, (i < DEPTH - 1) ? 32'h1 : 32'h0);
        end
        prog_valid = 1'b0;
        pulseStart();
        for (int j = 0; j <= DEPTH; j++) begin
            frameTick();
            if (j < DEPTH) begin
                expectAt(cyc, "full_btn", SEL_BTN, 32'(j + 1));
                expectAt(cyc, "full_sw",  SEL_SW,  32'(j % 16));
                expectAt(cyc, "full_idx", SEL_IDX, 32'(j));
            end else begin
                doneQ.push_back(cyc);
                expectAt(cyc, "full_fcnt", SEL_FCNT, 32'(DEPTH));
            end
            step();
        end

        // Single entry with zero duration lasts one frame
        clear = 1'b1;
        step();
        clear = 1'b0;
        progWrite(4'hA, 7'h10, 16'd0);
        btn_live = 7'h7F;
        pulseStart();
        frameTick();
        expectAt(cyc, "zero_btn", SEL_BTN, 32'h10);
        expectAt(cyc, "zero_sw",  SEL_SW,  32'hA);
        step();
        frameTick();
        doneQ.push_back(cyc);
        expectAt(cyc, "zero_done_btn", SEL_BTN, 32'h10);
        step();
        expectAt(cyc, "zero_idle_btn", SEL_BTN, 32'h7F);

        // Reset during playback
        pulseStart();
        frameTick();
        expectAt(cyc, "pre_rst_busy", SEL_BUSY, 32'h1);
        step();
        btn_live = 7'h2A;
        reset = 1'b1;
        step();
        reset = 1'b0;
        expectAt(cyc, "midrst_btn",  SEL_BTN,  32'h0);
        expectAt(cyc, "midrst_fcnt", SEL_FCNT, 32'h0);
        expectAt(cyc, "midrst_busy", SEL_BUSY, 32'h0);
        step();
        expectAt(cyc, "postrst_ready", SEL_READY, 32'h1);
        expectAt(cyc, "postrst_btn",   SEL_BTN,   32'h2A);
        pulseStart();
        expectAt(cyc, "postrst_count0", SEL_BUSY, 32'h0);
        step(); step(); step();
    endtask

    task automatic checkOutput();
        foreach (expQ[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s never sampled at cyc=%0d expected=%0h",
                     expQ[i].name, expQ[i].cyc, expQ[i].val);
        end
        foreach (doneQ[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_missing cyc=%0d got=0 expected=1", doneQ[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
